rr_psel_gen: RTL and testbench

- Parametrised multi-grant rotating-priority selector. Next generation of the fixed-priority multi-grant selector used for physical-register and free-slot allocation.
- Grants up to REQS requesters per cycle. Scanning starts at a registered rotating pointer instead of a fixed end, which removes starvation of high-index entries.
- Adds a per-cycle grant limit (want), encoded grant indices per slot, and a grant count.
- Sits between free-list/RS-entry valid vectors and dispatch/issue logic.

---
 rtl/rr_psel_gen.sv | 129 ++++++++++++
 tb/tb_rr_psel_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_psel_gen.sv
// Multi-grant rotating-priority selector: up to REQS requesters granted per cycle,
// scanning from a registered pointer that advances past the last committed grant.
module rr_psel_gen #(
  parameter int WIDTH = 64,
  parameter int REQS  = 2,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(REQS + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    en,
  input  logic [CNT_W-1:0]        want,
  input  logic [WIDTH-1:0]        req,
  output logic [WIDTH-1:0]        gnt,
  output logic [WIDTH*REQS-1:0]   gnt_bus,
  output logic [IDX_W*REQS-1:0]   gnt_idx,
  output logic [REQS-1:0]         gnt_valid,
  output logic [CNT_W-1:0]        gnt_cnt,
  output logic                    empty,
  output logic [IDX_W-1:0]        ptr
);

  localparam logic [IDX_W:0]   WIDTH_L = (IDX_W+1)'(WIDTH);
  localparam logic [IDX_W-1:0] LAST_L  = IDX_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] REQS_L  = CNT_W'(REQS);

  logic [IDX_W-1:0]      ptr_r;
  logic [2*WIDTH-1:0]    dbl_s;
  logic [2*WIDTH-1:0]    rot_full_s;
  logic [WIDTH-1:0]      rot_s;
  logic [WIDTH-1:0]      rem_s;
  logic [CNT_W-1:0]      want_eff_s;
  logic                  found_s;
  logic [IDX_W-1:0]      pos_s;
  logic [IDX_W-1:0]      abs_s;
  logic [IDX_W-1:0]      last_s;
  logic [WIDTH-1:0]      gnt_s;
  logic [WIDTH*REQS-1:0] bus_s;
  logic [IDX_W*REQS-1:0] idx_s;
  logic [REQS-1:0]       valid_s;
  logic [CNT_W-1:0]      cnt_s;

  // Maps a rotated position back to a line index, wrapping modulo WIDTH
  // (one subtraction suffices because both operands are below WIDTH).
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                input logic [IDX_W-1:0] off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= WIDTH_L) begin
      sum = sum - WIDTH_L;
    end else begin
      sum = sum;
    end
    return sum[IDX_W-1:0];
  endfunction

  // Rotate requests so bit 0 is the line at ptr; doubling handles non-power-of-two WIDTH.
  always_comb begin
    dbl_s      = {req, req};
    rot_full_s = dbl_s >> ptr_r;
    rot_s      = rot_full_s[WIDTH-1:0];
  end

  // Peel off the lowest remaining rotated request per slot until the clamped limit is reached.
  always_comb begin
    rem_s      = rot_s;
    want_eff_s = (want > REQS_L) ? REQS_L : want;
    found_s    = 1'b0;
    pos_s      = '0;
    abs_s      = '0;
    last_s     = '0;
    gnt_s      = '0;
    bus_s      = '0;
    idx_s      = '0;
    valid_s    = '0;
    cnt_s      = '0;
    for (int s = 0; s < REQS; s++) begin
      found_s = 1'b0;
      pos_s   = '0;
      for (int j = WIDTH - 1; j >= 0; j--) begin
        found_s = found_s | rem_s[j];
        pos_s   = rem_s[j] ? IDX_W'(j) : pos_s;
      end
      if (found_s && (CNT_W'(s) < want_eff_s)) begin
        rem_s[pos_s]               = 1'b0;
        abs_s                      = wrap_add(ptr_r, pos_s);
        valid_s[s]                 = 1'b1;
        cnt_s                      = cnt_s + CNT_W'(1);
        idx_s[s*IDX_W +: IDX_W]    = abs_s;
        bus_s[s*WIDTH +: WIDTH]    = WIDTH'(1) << abs_s;
        gnt_s                      = gnt_s | (WIDTH'(1) << abs_s);
        last_s                     = abs_s;
      end else begin
        rem_s = rem_s;
      end
    end
  end

  // Grants are suppressed while reset is held; empty always tracks req.
  always_comb begin
    empty = ~|req;
    ptr   = ptr_r;
    if (reset) begin
      gnt       = '0;
      gnt_bus   = '0;
      gnt_idx   = '0;
      gnt_valid = '0;
      gnt_cnt   = '0;
    end else begin
      gnt       = gnt_s;
      gnt_bus   = bus_s;
      gnt_idx   = idx_s;
      gnt_valid = valid_s;
      gnt_cnt   = cnt_s;
    end
  end

  // Pointer moves just past the last committed grant; holds when nothing is committed.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (en && (cnt_s != '0)) begin
      ptr_r <= (last_s == LAST_L) ? '0 : last_s + IDX_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: tb/tb_rr_psel_gen.sv
// Bench for rr_psel_gen: directed scenarios on an 8-line/2-grant instance and a
// randomised sweep on a 6-line/3-grant instance against a scan-order reference model.
module tb_rr_psel_gen;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        en8, empty8;
  logic [1:0]  want8, val8, cnt8;
  logic [7:0]  req8, gnt8;
  logic [15:0] bus8;
  logic [5:0]  idx8;
  logic [2:0]  ptr8;

  logic        en6, empty6;
  logic [1:0]  want6, cnt6;
  logic [5:0]  req6, gnt6;
  logic [17:0] bus6;
  logic [8:0]  idx6;
  logic [2:0]  val6, ptr6;

  int checks = 0;
  int fails = 0;
  int exp_cnt;
  int exp_idx[4];

  rr_psel_gen #(.WIDTH(8), .REQS(2)) u8 (
    .clock(clk), .reset(reset), .en(en8), .want(want8), .req(req8),
    .gnt(gnt8), .gnt_bus(bus8), .gnt_idx(idx8), .gnt_valid(val8),
    .gnt_cnt(cnt8), .empty(empty8), .ptr(ptr8)
  );

  rr_psel_gen #(.WIDTH(6), .REQS(3)) u6 (
    .clock(clk), .reset(reset), .en(en6), .want(want6), .req(req6),
    .gnt(gnt6), .gnt_bus(bus6), .gnt_idx(idx6), .gnt_valid(val6),
    .gnt_cnt(cnt6), .empty(empty6), .ptr(ptr6)
  );

  // Walk lines in order p, p+1, ... (mod w) and hand them to slots until the limit.
  task automatic model(input int w, input int reqs, input logic [63:0] r,
                       input int wnt, input int p);
    int lim;
    int i;
    lim = (wnt < reqs) ? wnt : reqs;
    exp_cnt = 0;
    for (int k = 0; k < 4; k++) exp_idx[k] = 0;
    for (int o = 0; o < w; o++) begin
      i = (p + o) % w;
      if (r[i] && exp_cnt < lim) begin
        exp_idx[exp_cnt] = i;
        exp_cnt++;
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; en8 = 1'b1; want8 = 2'd2; req8 = 8'hA5;
    en6 = 1'b0; want6 = 2'd0; req6 = 6'd0;
    tick; tick;
    checks++; if (gnt8 !== 8'd0) begin fails++; $display("FAIL rst_gnt: got %h expected 00", gnt8); end
    checks++; if (bus8 !== 16'd0) begin fails++; $display("FAIL rst_bus: got %h expected 0000", bus8); end
    checks++; if (idx8 !== 6'd0 || val8 !== 2'd0 || cnt8 !== 2'd0) begin fails++; $display("FAIL rst_slots: idx %h valid %b cnt %0d expected all 0", idx8, val8, cnt8); end
    checks++; if (empty8 !== 1'b0) begin fails++; $display("FAIL rst_empty0: got %b expected 0", empty8); end
    checks++; if (ptr8 !== 3'd0 || ptr6 !== 3'd0) begin fails++; $display("FAIL rst_ptr: got %0d/%0d expected 0/0", ptr8, ptr6); end
    req8 = 8'd0; #1;
    checks++; if (empty8 !== 1'b1) begin fails++; $display("FAIL rst_empty1: got %b expected 1", empty8); end
    reset = 1'b0; en8 = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    req8 = 8'b1001_0110; want8 = 2'd2; en8 = 1'b1; #1;
    checks++; if (idx8 !== {3'd2, 3'd1}) begin fails++; $display("FAIL basic_idx1: got %h expected %h", idx8, {3'd2, 3'd1}); end
    checks++; if (gnt8 !== 8'b0000_0110) begin fails++; $display("FAIL basic_gnt1: got %b expected 00000110", gnt8); end
    checks++; if (bus8 !== {8'b0000_0100, 8'b0000_0010}) begin fails++; $display("FAIL basic_bus1: got %h expected 0402", bus8); end
    checks++; if (cnt8 !== 2'd2 || val8 !== 2'b11) begin fails++; $display("FAIL basic_cnt1: cnt %0d valid %b expected 2 11", cnt8, val8); end
    tick;
    checks++; if (ptr8 !== 3'd3) begin fails++; $display("FAIL basic_ptr1: got %0d expected 3", ptr8); end
    checks++; if (idx8 !== {3'd7, 3'd4}) begin fails++; $display("FAIL basic_idx2: got %h expected %h", idx8, {3'd7, 3'd4}); end
    checks++; if (gnt8 !== 8'b1001_0000) begin fails++; $display("FAIL basic_gnt2: got %b expected 10010000", gnt8); end
    tick;
    checks++; if (ptr8 !== 3'd0) begin fails++; $display("FAIL basic_ptr2: got %0d expected 0", ptr8); end
  endtask

  task automatic test_wrap;
    req8 = 8'b0010_0000; want8 = 2'd1; en8 = 1'b1;
    tick;
    checks++; if (ptr8 !== 3'd6) begin fails++; $display("FAIL wrap_setup: got %0d expected 6", ptr8); end
    req8 = 8'b0100_0001; want8 = 2'd2; #1;
    checks++; if (idx8 !== {3'd0, 3'd6}) begin fails++; $display("FAIL wrap_idx: got %h expected %h", idx8, {3'd0, 3'd6}); end
    checks++; if (gnt8 !== 8'b0100_0001) begin fails++; $display("FAIL wrap_gnt: got %b expected 01000001", gnt8); end
    tick;
    checks++; if (ptr8 !== 3'd1) begin fails++; $display("FAIL wrap_ptr: got %0d expected 1", ptr8); end
  endtask

  task automatic test_limit;
    req8 = 8'b1000_0000; want8 = 2'd1; en8 = 1'b1;
    tick;
    checks++; if (ptr8 !== 3'd0) begin fails++; $display("FAIL limit_setup: got %0d expected 0", ptr8); end
    req8 = 8'b0000_1110; #1;
    checks++; if (val8 !== 2'b01 || cnt8 !== 2'd1) begin fails++; $display("FAIL limit_cnt: valid %b cnt %0d expected 01 1", val8, cnt8); end
    checks++; if (idx8 !== {3'd0, 3'd1} || bus8[15:8] !== 8'd0) begin fails++; $display("FAIL limit_slots: idx %h bus %h expected 01 and slot1 bus 0", idx8, bus8); end
    tick;
    checks++; if (ptr8 !== 3'd2) begin fails++; $display("FAIL limit_ptr: got %0d expected 2", ptr8); end
    want8 = 2'd3; en8 = 1'b0; #1;
    checks++; if (cnt8 !== 2'd2 || val8 !== 2'b11 || idx8 !== {3'd3, 3'd2}) begin fails++; $display("FAIL limit_clamp: cnt %0d valid %b idx %h expected 2 11 1a", cnt8, val8, idx8); end
    tick;
  endtask

  task automatic test_empty_hold;
    req8 = 8'd0; want8 = 2'd2; en8 = 1'b1; #1;
    checks++; if (empty8 !== 1'b1 || gnt8 !== 8'd0 || cnt8 !== 2'd0) begin fails++; $display("FAIL empty_out: empty %b gnt %h cnt %0d expected 1 00 0", empty8, gnt8, cnt8); end
    tick;
    checks++; if (ptr8 !== 3'd2) begin fails++; $display("FAIL empty_ptr: got %0d expected 2", ptr8); end
    req8 = 8'hFF; want8 = 2'd0; #1;
    checks++; if (cnt8 !== 2'd0 || gnt8 !== 8'd0) begin fails++; $display("FAIL want0_out: cnt %0d gnt %h expected 0 00", cnt8, gnt8); end
    tick;
    checks++; if (ptr8 !== 3'd2) begin fails++; $display("FAIL want0_ptr: got %0d expected 2", ptr8); end
    want8 = 2'd2; en8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (idx8 !== {3'd3, 3'd2} || ptr8 !== 3'd2) begin fails++; $display("FAIL hold_%0d: idx %h ptr %0d expected 1a 2", k, idx8, ptr8); end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    req8 = 8'b0001_0000; want8 = 2'd1; en8 = 1'b1;
    tick;
    checks++; if (ptr8 !== 3'd5) begin fails++; $display("FAIL midrst_setup: got %0d expected 5", ptr8); end
    req8 = 8'hFF; want8 = 2'd2; reset = 1'b1; #1;
    checks++; if (gnt8 !== 8'd0 || cnt8 !== 2'd0 || idx8 !== 6'd0 || bus8 !== 16'd0 || val8 !== 2'd0) begin fails++; $display("FAIL midrst_out: gnt %h cnt %0d idx %h expected all 0", gnt8, cnt8, idx8); end
    tick;
    reset = 1'b0; #1;
    checks++; if (ptr8 !== 3'd0 || idx8 !== {3'd1, 3'd0}) begin fails++; $display("FAIL midrst_after: ptr %0d idx %h expected 0 08", ptr8, idx8); end
    en8 = 1'b0;
    tick;
  endtask

  task automatic test_random_sweep;
    int mptr;
    logic rr;
    logic [17:0] eb;
    logic [8:0] ei;
    logic [5:0] eg;
    logic [2:0] ev;
    reset = 1'b1; tick; reset = 1'b0;
    mptr = 0;
    for (int c = 0; c < 10000; c++) begin
      rr = ($urandom_range(0, 63) == 0);
      reset = rr;
      req6 = ($urandom_range(0, 3) == 0) ? 6'($urandom & $urandom) : 6'($urandom);
      want6 = 2'($urandom_range(0, 3));
      en6 = 1'($urandom_range(0, 1));
      #1;
      if (rr) begin
        exp_cnt = 0;
        for (int k = 0; k < 4; k++) exp_idx[k] = 0;
      end else begin
        model(6, 3, 64'(req6), int'(want6), mptr);
      end
      eb = '0; ei = '0; eg = '0; ev = '0;
      for (int k = 0; k < exp_cnt; k++) begin
        eb[k*6 +: 6] = 6'd1 << exp_idx[k];
        ei[k*3 +: 3] = 3'(exp_idx[k]);
        eg[exp_idx[k]] = 1'b1;
        ev[k] = 1'b1;
      end
      checks++; if (int'(cnt6) != exp_cnt) begin fails++; $display("FAIL rnd_cnt c%0d: got %0d expected %0d", c, cnt6, exp_cnt); end
      checks++; if (val6 !== ev) begin fails++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, val6, ev); end
      checks++; if (idx6 !== ei) begin fails++; $display("FAIL rnd_idx c%0d: got %h expected %h", c, idx6, ei); end
      checks++; if (bus6 !== eb) begin fails++; $display("FAIL rnd_bus c%0d: got %h expected %h", c, bus6, eb); end
      checks++; if (gnt6 !== eg) begin fails++; $display("FAIL rnd_gnt c%0d: got %b expected %b", c, gnt6, eg); end
      checks++; if (empty6 !== (req6 == 6'd0)) begin fails++; $display("FAIL rnd_empty c%0d: got %b req %b", c, empty6, req6); end
      checks++; if (int'(ptr6) != mptr || ptr6 >= 3'd6) begin fails++; $display("FAIL rnd_ptr c%0d: got %0d expected %0d", c, ptr6, mptr); end
      checks++; if ($countones(gnt6) != int'(cnt6)) begin fails++; $display("FAIL rnd_popcnt c%0d: popcount %0d cnt %0d", c, $countones(gnt6), cnt6); end
      for (int s = 0; s < 3; s++) begin
        checks++; if (!$onehot0(bus6[s*6 +: 6])) begin fails++; $display("FAIL rnd_onehot c%0d slot %0d: got %b", c, s, bus6[s*6 +: 6]); end
        for (int t = s + 1; t < 3; t++) begin
          checks++; if ((bus6[s*6 +: 6] & bus6[t*6 +: 6]) !== 6'd0) begin fails++; $display("FAIL rnd_unique c%0d slots %0d/%0d: %b %b", c, s, t, bus6[s*6 +: 6], bus6[t*6 +: 6]); end
        end
      end
      tick;
      if (rr) mptr = 0;
      else if (en6 && exp_cnt > 0) mptr = (exp_idx[exp_cnt-1] + 1) % 6;
    end
    reset = 1'b0; en6 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_limit;
    test_empty_hold;
    test_reset_mid;
    test_random_sweep;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
